// File: rtl/lipsi_exec_ctrl.sv
// Lipsi execution controller: program load, core reset/release, paced or single-stepped clock-enable.
// Optional breakpoint support is compiled in with `define LIPSI_CTRL_BKPT_EN.
module lipsi_exec_ctrl #(
   parameter int unsigned DIV_MAX = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   input  logic        load_last,
   output logic        load_ready,
   input  logic        run_req,
   input  logic        step_req,
   input  logic        halt_req,
   input  logic [7:0]  cpu_pc,
   input  logic [7:0]  cpu_instr,
`ifdef LIPSI_CTRL_BKPT_EN
   input  logic        bkpt_en,
   input  logic [7:0]  bkpt_addr,
   output logic        bkpt_hit,
`endif
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [7:0]  imem_wdata,
   output logic        cpu_rst,
   output logic        cpu_ce,
   output logic [2:0]  state,
   output logic        halted,
   output logic [15:0] cycle_count
);

   localparam int unsigned TickW = $clog2(DIV_MAX);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLoad   = 3'd1,
      StRstCpu = 3'd2,
      StPause  = 3'd3,
      StRun    = 3'd4,
      StStep   = 3'd5,
      StDone   = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         wptr_q;
   logic [TickW-1:0]   tick_q;
   logic               rst_cnt_q;
   logic               step_armed_q;
   logic               step_term_q;

   logic               accept;
   logic               term;
   logic               tick_term;
   logic               bkpt_stop;
   logic               ce_d;
   logic [7:0]         wr_addr;

   assign accept    = load_valid && load_ready;
   assign term      = (cpu_instr == 8'hFF) || (cpu_pc == 8'hFF);
   assign tick_term = (tick_q == TickW'(DIV_MAX - 1));
   // The first byte of a load always goes to address 0, whatever the stale pointer holds.
   assign wr_addr   = (state_q == StLoad) ? wptr_q : 8'h00;
   assign state     = state_q;

`ifdef LIPSI_CTRL_BKPT_EN
   logic first_tick_q;
   assign bkpt_stop = bkpt_en && (cpu_pc == bkpt_addr) && !first_tick_q;
`else
   assign bkpt_stop = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ce_d    = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = load_last ? StRstCpu : StLoad;
            end else if (run_req) begin
               state_d = StRstCpu;
            end
         end
         StLoad: begin
            if (accept && (load_last || wptr_q == 8'hFF)) begin
               state_d = StRstCpu;
            end
         end
         StRstCpu: begin
            if (rst_cnt_q) begin
               state_d = StPause;
            end
         end
         StPause: begin
            if (run_req) begin
               state_d = StRun;
            end else if (step_req && step_armed_q) begin
               state_d = StStep;
               ce_d    = !term;
            end
         end
         StRun: begin
            if (halt_req) begin
               state_d = StPause;
            end else if (tick_term) begin
               if (bkpt_stop) begin
                  state_d = StPause;
               end else if (term) begin
                  state_d = StDone;
               end else begin
                  ce_d = 1'b1;
               end
            end
         end
         StStep: begin
            state_d = step_term_q ? StDone : StPause;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         wptr_q       <= 8'h00;
         tick_q       <= '0;
         rst_cnt_q    <= 1'b0;
         step_armed_q <= 1'b1;
         step_term_q  <= 1'b0;
         load_ready   <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= 8'h00;
         imem_wdata   <= 8'h00;
         cpu_rst      <= 1'b1;
         cpu_ce       <= 1'b0;
         halted       <= 1'b0;
         cycle_count  <= 16'h0000;
`ifdef LIPSI_CTRL_BKPT_EN
         first_tick_q <= 1'b1;
         bkpt_hit     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         load_ready <= (state_d == StIdle) || (state_d == StLoad) || (state_d == StDone);
         cpu_rst    <= (state_d == StIdle) || (state_d == StLoad) || (state_d == StRstCpu);
         cpu_ce     <= ce_d;
         imem_we    <= accept;

         if (accept) begin
            imem_addr  <= wr_addr;
            imem_wdata <= load_data;
            wptr_q     <= (wr_addr == 8'hFF) ? wr_addr : wr_addr + 8'd1;
         end

         rst_cnt_q <= (state_q == StRstCpu) && !rst_cnt_q;

         // Tick counter only advances while staying in RUN; any exit restarts a full period.
         if (state_q == StRun && state_d == StRun) begin
            tick_q <= tick_term ? '0 : tick_q + TickW'(1);
         end else begin
            tick_q <= '0;
         end

         if (state_q == StRstCpu) begin
            cycle_count <= 16'h0000;
         end else if (ce_d && cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
         end

         if (state_q == StRstCpu) begin
            halted <= 1'b0;
         end else if (state_d == StDone) begin
            halted <= 1'b1;
         end

         // A held step_req must be seen low in PAUSE before it can step again.
         if (state_q == StRstCpu) begin
            step_armed_q <= 1'b1;
         end else if (state_q == StPause) begin
            if (state_d == StStep) begin
               step_armed_q <= 1'b0;
            end else if (!step_req) begin
               step_armed_q <= 1'b1;
            end
         end

         if (state_q == StPause && state_d == StStep) begin
            step_term_q <= term;
         end

`ifdef LIPSI_CTRL_BKPT_EN
         if (state_q != StRun) begin
            first_tick_q <= 1'b1;
         end else if (tick_term) begin
            first_tick_q <= 1'b0;
         end

         if (state_q == StRstCpu || (state_q == StPause && state_d != StPause)) begin
            bkpt_hit <= 1'b0;
         end else if (state_q == StRun && !halt_req && tick_term && bkpt_stop) begin
            bkpt_hit <= 1'b1;
         end
`endif
      end
   end

endmodule
